// File: rtl/jammer_conv_pkg.sv
// Shared types and helpers for the jammer_conv FIR engine.
//   state_t    : frame FSM states (IDLE, RUN, FLUSH)
//   acc_width  : full-precision accumulator width for a WIDTH x CW x NUM filter
//   sat_round  : round half-up, arithmetic shift, clamp to a signed output width
package jammer_conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int unsigned MAX_W = 128;
  typedef logic signed [MAX_W-1:0] wide_t;

  function automatic int unsigned acc_width(input int unsigned w,
                                            input int unsigned cw,
                                            input int unsigned num);
    return w + cw + $clog2(num);
  endfunction

  // Evaluated at MAX_W so the rounding add cannot wrap. When the output is
  // wide enough the clamp never triggers and this reduces to sign extension.
  function automatic wide_t sat_round(input wide_t       acc,
                                      input int unsigned shift,
                                      input int unsigned out_w);
    wide_t r;
    wide_t hi;
    wide_t lo;
    r = acc;
    if (shift > 0) begin
      r = r + (wide_t'(1) <<< (shift - 1));
    end
    r  = r >>> shift;
    hi = (wide_t'(1) <<< (out_w - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (out_w - 1));
    if (r > hi) begin
      return hi;
    end
    if (r < lo) begin
      return lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/jammer_conv_mac_tree.sv
// Two-stage multiply/accumulate datapath for jammer_conv_fir.
//   clk, rst       : clock, async active-high reset
//   i_vld, i_last  : sample tag and end-of-frame tag for the current tap vector
//   i_taps         : tap vector, element 0 is the newest sample
//   i_coefs        : coefficient vector, element k multiplies tap k
//   o_data         : rounded, shifted and saturated sum
//   o_vld, o_last  : tags delayed by two cycles
//   o_stage1_vld   : product stage holds a valid entry
module jammer_conv_mac_tree
  import jammer_conv_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CW    = 16,
  parameter int unsigned NUM   = 8,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned SHIFT = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_vld,
  input  logic                        i_last,
  input  logic [NUM-1:0][WIDTH-1:0]   i_taps,
  input  logic [NUM-1:0][CW-1:0]      i_coefs,
  output logic signed [OUT_W-1:0]     o_data,
  output logic                        o_vld,
  output logic                        o_last,
  output logic                        o_stage1_vld
);

  localparam int unsigned ACC_W = acc_width(WIDTH, CW, NUM);
  localparam int unsigned PW    = WIDTH + CW;

  logic signed [PW-1:0]    r_prod [NUM];
  logic                    r_vld1;
  logic                    r_last1;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [OUT_W-1:0] w_scaled;
  logic signed [OUT_W-1:0] r_data;
  logic                    r_vld2;
  logic                    r_last2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < NUM; k++) begin
        r_prod[k] <= '0;
      end
      r_vld1  <= 1'b0;
      r_last1 <= 1'b0;
    end else begin
      r_vld1  <= i_vld;
      r_last1 <= i_vld & i_last;
      if (i_vld) begin
        for (int unsigned k = 0; k < NUM; k++) begin
          r_prod[k] <= PW'($signed(i_taps[k])) * PW'($signed(i_coefs[k]));
        end
      end
    end
  end

  always_comb begin
    w_sum = '0;
    for (int unsigned k = 0; k < NUM; k++) begin
      w_sum = w_sum + ACC_W'(r_prod[k]);
    end
    w_scaled = OUT_W'(sat_round(wide_t'(w_sum), SHIFT, OUT_W));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_vld2  <= 1'b0;
      r_last2 <= 1'b0;
    end else begin
      r_vld2  <= r_vld1;
      r_last2 <= r_last1;
      if (r_vld1) begin
        r_data <= w_scaled;
      end
    end
  end

  assign o_data       = r_data;
  assign o_vld        = r_vld2;
  assign o_last       = r_last2;
  assign o_stage1_vld = r_vld1;

endmodule

// File: rtl/jammer_conv_fir.sv
// Pipelined FIR convolution engine with double-buffered coefficients.
//   clk, rst             : clock, async active-high reset
//   coe, coes_vld        : serial coefficient load into the shadow bank (h[0] first)
//   coe_ready            : shadow bank can accept a word
//   sig_in, sig_vld      : input sample and its valid
//   last_sig             : final sample of the frame
//   sig_ready            : samples accepted (low while flushing the tail)
//   sig_out, out_vld     : filtered output, two cycles after the shift
//   out_last             : final tail output of the frame
//   busy                 : frame in progress or pipeline not yet drained
module jammer_conv_fir
  import jammer_conv_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CW    = 16,
  parameter int unsigned NUM   = 8,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned SHIFT = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [CW-1:0]    coe,
  input  logic                    coes_vld,
  output logic                    coe_ready,
  input  logic signed [WIDTH-1:0] sig_in,
  input  logic                    sig_vld,
  input  logic                    last_sig,
  output logic                    sig_ready,
  output logic signed [OUT_W-1:0] sig_out,
  output logic                    out_vld,
  output logic                    out_last,
  output logic                    busy
);

  localparam int unsigned CNT_W = $clog2(NUM + 1);
  localparam int unsigned FC_W  = $clog2(NUM);

  state_t                    r_state;
  state_t                    w_state_next;
  logic [NUM-1:0][CW-1:0]    r_shadow;
  logic [NUM-1:0][CW-1:0]    r_active;
  logic [NUM-1:0][CW-1:0]    w_coefs;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_pending;
  logic [NUM-1:0][WIDTH-1:0] r_taps;
  logic [NUM-1:0][WIDTH-1:0] w_taps_next;
  logic [FC_W-1:0]           r_flush_cnt;
  logic                      w_coe_acc;
  logic                      w_sig_acc;
  logic                      w_inject;
  logic                      w_inject_last;
  logic                      w_shift;
  logic                      w_swap;
  logic                      w_stage1_vld;

  always_comb begin
    coe_ready     = ~r_pending;
    sig_ready     = (r_state != FLUSH);
    w_coe_acc     = coes_vld & ~r_pending;
    w_sig_acc     = sig_vld & (r_state != FLUSH);
    w_inject      = (r_state == FLUSH);
    w_inject_last = w_inject & (r_flush_cnt == FC_W'(NUM - 2));
    w_shift       = w_sig_acc | w_inject;
    w_swap        = r_pending & (r_state == IDLE);
  end

  // The datapath multiplies the post-shift tap vector in the same cycle the
  // sample is accepted, so a swap landing on that edge must already present
  // the new bank; the whole frame then uses it consistently.
  always_comb begin
    w_coefs = w_swap ? r_shadow : r_active;
    w_taps_next[0] = w_sig_acc ? sig_in : '0;
    for (int unsigned k = 1; k < NUM; k++) begin
      w_taps_next[k] = r_taps[k-1];
    end
  end

  // Coefficient banks: serial load into shadow, swap only while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow  <= '0;
      r_active  <= '0;
      r_cnt     <= '0;
      r_pending <= 1'b0;
    end else if (w_swap) begin
      r_active  <= r_shadow;
      r_cnt     <= '0;
      r_pending <= 1'b0;
    end else if (w_coe_acc) begin
      for (int unsigned k = 0; k < NUM; k++) begin
        if (r_cnt == CNT_W'(k)) begin
          r_shadow[k] <= coe;
        end
      end
      r_cnt <= r_cnt + CNT_W'(1);
      if (r_cnt == CNT_W'(NUM - 1)) begin
        r_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_sig_acc) begin
          w_state_next = last_sig ? FLUSH : RUN;
        end
      end
      RUN: begin
        if (w_sig_acc && last_sig) begin
          w_state_next = FLUSH;
        end
      end
      FLUSH: begin
        if (w_inject_last) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Delay line and flush injection counter. The last injection's products
  // are taken from w_taps_next, so the line can be cleared on that edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_taps      <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_inject_last) begin
        r_taps <= '0;
      end else if (w_shift) begin
        r_taps <= w_taps_next;
      end
      if (w_inject) begin
        r_flush_cnt <= w_inject_last ? '0 : r_flush_cnt + FC_W'(1);
      end
    end
  end

  jammer_conv_mac_tree #(
    .WIDTH (WIDTH),
    .CW    (CW),
    .NUM   (NUM),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_mac (
    .clk          (clk),
    .rst          (rst),
    .i_vld        (w_shift),
    .i_last       (w_inject_last),
    .i_taps       (w_taps_next),
    .i_coefs      (w_coefs),
    .o_data       (sig_out),
    .o_vld        (out_vld),
    .o_last       (out_last),
    .o_stage1_vld (w_stage1_vld)
  );

  assign busy = (r_state != IDLE) | w_stage1_vld | out_vld;

endmodule
